// File: rtl/npu_mem_pkg.sv
// Shared constants and types for the result-drain path.
// Build option: DRAIN_ROW_LAST_EN adds a per-element row-end tag to the stored FIFO word.
// Contents: ADDR_W/DATA_W/DIM_W widths, CNT_W element-count width, state_t, FIFO_W.
package npu_mem_pkg;

  localparam int ADDR_W = 14;        // scratchpad word-address width
  localparam int DATA_W = 16;        // element width (FP16 bit pattern)
  localparam int DIM_W  = 10;        // row/col size width
  localparam int CNT_W  = 2 * DIM_W; // element count row_size*col_size

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef DRAIN_ROW_LAST_EN
  // Data plus the row-end tag travel together through the skid FIFO.
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

endpackage

// File: rtl/matrix_result_drain_if.sv
// Output element stream of the result drain (drain is master, host FIFO is slave).
// Build option: DRAIN_ROW_LAST_EN adds out_row_last.
// Signals: out_data (element), out_valid, out_ready, out_last (final element), [out_row_last].
interface matrix_result_drain_if;

  logic [npu_mem_pkg::DATA_W-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;

`ifdef DRAIN_ROW_LAST_EN
  logic                           out_row_last;

  modport master (output out_data, out_valid, out_last, out_row_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_row_last, output out_ready);
`else
  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, output out_ready);
`endif

endinterface

// File: rtl/drain_skid_fifo.sv
// 2-entry FIFO holding read data between the scratchpad port and the output stream.
// Latency: push visible at head on the cycle after the push edge; head is a plain mux of storage.
// Backpressure: no internal guard, the caller keeps push off when full (credit on count).
// Ports: clk, reset (sync, active-high), push/push_data, pop, count (0..2), head.
module drain_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = entry[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/matrix_result_drain.sv
// Streams a finished result matrix from the dest scratchpad to the host, address ascending.
// Latency: start at edge T -> first address in cycle T+1 -> out_valid after edge T+2; 1 elem/cycle.
// Backpressure: reads issue only while FIFO count + inflight leaves room; outputs hold while stalled.
// Ports: clk, reset (sync, active-high), start/done, start_address/row_size/col_size (latched at start),
//        mem_address/mem_readdata (1-cycle read latency), stream (master: out_data/valid/ready/last).
// Build option: DRAIN_ROW_LAST_EN adds stream.out_row_last, high on the last element of each row.
module matrix_result_drain
  import npu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [DIM_W-1:0]  row_size,
  input  logic [DIM_W-1:0]  col_size,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_readdata,
  matrix_result_drain_if.master stream
);

  state_t            state;
  logic [DIM_W-1:0]  row_lat;
  logic [DIM_W-1:0]  col_lat;
  logic [DIM_W-1:0]  row_cnt;
  logic [DIM_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  out_cnt;
  logic              issue_done;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  logic [FIFO_W-1:0] push_data;

  assign pop = stream.out_valid & stream.out_ready;

  // A slot freed by this cycle's pop counts as room, so a full-rate stream
  // keeps one element in the FIFO and one read in flight.
  assign issue = (state == RUN) && !issue_done &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef DRAIN_ROW_LAST_EN
  logic inflight_row_last;
  assign push_data           = {inflight_row_last, mem_readdata};
  assign stream.out_data     = fifo_head[DATA_W-1:0];
  assign stream.out_row_last = stream.out_valid & fifo_head[DATA_W];
`else
  assign push_data           = mem_readdata;
  assign stream.out_data     = fifo_head;
`endif

  assign stream.out_valid = (fifo_count != 2'd0);
  // Beat position is tracked at the output, so issue-side state never affects it.
  assign stream.out_last  = stream.out_valid && (out_cnt == (total - CNT_W'(1)));

  drain_skid_fifo #(
    .W (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b1;
      mem_address <= start_address;
      row_lat     <= '0;
      col_lat     <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      total       <= '0;
      out_cnt     <= '0;
      issue_done  <= 1'b0;
      inflight    <= 1'b0;
`ifdef DRAIN_ROW_LAST_EN
      inflight_row_last <= 1'b0;
`endif
    end else begin
      inflight <= issue;
`ifdef DRAIN_ROW_LAST_EN
      if (issue) begin
        inflight_row_last <= (row_cnt == (row_lat - DIM_W'(1)));
      end
`endif
      if (state == IDLE) begin
        mem_address <= start_address;
        // Empty matrices never leave IDLE, so done stays high.
        if (start && (row_size != '0) && (col_size != '0)) begin
          state      <= RUN;
          done       <= 1'b0;
          row_lat    <= row_size;
          col_lat    <= col_size;
          total      <= CNT_W'(row_size) * CNT_W'(col_size);
          row_cnt    <= '0;
          col_cnt    <= '0;
          out_cnt    <= '0;
          issue_done <= 1'b0;
        end
      end else begin
        if (issue) begin
          mem_address <= mem_address + ADDR_W'(1);
          if (row_cnt == (row_lat - DIM_W'(1))) begin
            row_cnt <= '0;
            col_cnt <= col_cnt + DIM_W'(1);
            if (col_cnt == (col_lat - DIM_W'(1))) begin
              issue_done <= 1'b1;
            end
          end else begin
            row_cnt <= row_cnt + DIM_W'(1);
          end
        end
        if (pop) begin
          out_cnt <= out_cnt + CNT_W'(1);
          if (stream.out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Self-checking bench for matrix_result_drain: scoreboard of expected beats built from the
// scratchpad contents, random/patterned out_ready, stall-stability and issue-bound checks.
// Covers reset values, full rate, backpressure, empty sizes, address wrap, mid-run reset, row tags.
module tb_matrix_result_drain;
  import npu_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] start_address;
  logic [DIM_W-1:0]  row_size;
  logic [DIM_W-1:0]  col_size;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_readdata;

  matrix_result_drain_if stream ();

  matrix_result_drain dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done          (done),
    .start_address (start_address),
    .row_size      (row_size),
    .col_size      (col_size),
    .mem_address   (mem_address),
    .mem_readdata  (mem_readdata),
    .stream        (stream)
  );

  always #5 clk = ~clk;

  // Scratchpad model with one cycle of read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) mem_readdata <= mem[mem_address];

  int checks = 0;
  int errors = 0;

  // Drains one matrix and scores every beat against a list built from mem.
  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 ready random ~70%.
  // abort_after: stop monitoring once that many beats are accepted (0 = run to done).
  task automatic run_drain(input string name, input logic [ADDR_W-1:0] base,
                           input int rows, input int cols, input int mode,
                           input int abort_after, input bit disturb, input bit check_lat);
    logic [DATA_W-1:0] exp_d[$];
    bit                exp_l[$];
    bit                exp_rl[$];
    int                n_total;
    int                beats, n, first_n, last_n, outstanding;
    bit                prev_v, prev_r, prev_l, rdy, aborted;
    logic [DATA_W-1:0] prev_d;
    logic [DATA_W-1:0] d;
    n_total = rows * cols;
    for (int k = 0; k < n_total; k++) begin
      exp_d.push_back(mem[ADDR_W'(int'(base) + k)]);
      exp_l.push_back(k == n_total - 1);
      exp_rl.push_back((k % rows) == rows - 1);
    end
    beats = 0; first_n = -1; last_n = -1;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0; aborted = 0;

    @(negedge clk);
    start_address = base;
    row_size      = DIM_W'(rows);
    col_size      = DIM_W'(cols);
    start         = 1'b1;
    stream.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s done_low: got %b exp 0", name, done);
    end
    checks++;
    if (mem_address !== base) begin
      errors++; $display("FAIL %s first_addr: got %h exp %h", name, mem_address, base);
    end

    while (n < 400) begin
      if (n > 1 && done === 1'b1) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 1);
        default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      stream.out_ready = rdy;

      if (prev_v && !prev_r) begin
        checks++;
        if (stream.out_valid !== 1'b1 || stream.out_data !== prev_d || stream.out_last !== prev_l) begin
          errors++;
          $display("FAIL %s stall_hold cyc %0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   name, n, stream.out_valid, stream.out_data, stream.out_last, prev_d, prev_l);
        end
      end

      // Reads in flight or buffered never exceed the two-entry capacity.
      outstanding = int'(ADDR_W'(mem_address - base));
      checks++;
      if (outstanding > beats + 2) begin
        errors++;
        $display("FAIL %s issue_bound cyc %0d: issued %0d accepted %0d", name, n, outstanding, beats);
      end

      if (stream.out_valid === 1'b1 && rdy) begin
        if (first_n < 0) first_n = n;
        checks++;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL %s extra_beat cyc %0d: got %h exp none", name, n, stream.out_data);
        end else begin
          d = exp_d.pop_front();
          if (stream.out_data !== d || stream.out_last !== exp_l[0]) begin
            errors++;
            $display("FAIL %s beat %0d: got d=%h last=%b exp d=%h last=%b",
                     name, beats + 1, stream.out_data, stream.out_last, d, exp_l[0]);
          end
          void'(exp_l.pop_front());
`ifdef DRAIN_ROW_LAST_EN
          checks++;
          if (stream.out_row_last !== exp_rl[0]) begin
            errors++;
            $display("FAIL %s row_last beat %0d: got %b exp %b", name, beats + 1, stream.out_row_last, exp_rl[0]);
          end
`endif
          void'(exp_rl.pop_front());
        end
        beats++;
        last_n = n;
        if (abort_after != 0 && beats == abort_after) begin
          aborted = 1;
          break;
        end
      end
      prev_v = (stream.out_valid === 1'b1);
      prev_r = rdy;
      prev_d = stream.out_data;
      prev_l = stream.out_last;

      if (disturb && n == 4) begin
        start = 1'b1; start_address = ~base; row_size = 10'd7; col_size = 10'd7;
      end
      if (disturb && n == 5) start = 1'b0;
      @(negedge clk);
      n++;
    end

    if (aborted) return;

    checks++;
    if (n >= 400) begin
      errors++; $display("FAIL %s timeout: got no done after %0d cycles exp done", name, n);
    end
    checks++;
    if (beats != n_total) begin
      errors++; $display("FAIL %s beat_count: got %0d exp %0d", name, beats, n_total);
    end
    checks++;
    if (last_n != n - 1 || stream.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_timing: got done at cyc %0d valid=%b exp cyc %0d valid=0",
               name, n, stream.out_valid, last_n + 1);
    end
    if (check_lat) begin
      checks++;
      if (first_n != 3) begin
        errors++; $display("FAIL %s first_valid_cyc: got %0d exp 3", name, first_n);
      end
      checks++;
      if (last_n - first_n != n_total - 1) begin
        errors++; $display("FAIL %s back_to_back: got span %0d exp %0d", name, last_n - first_n, n_total - 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [ADDR_W-1:0] base);
    checks++;
    if (done !== 1'b1 || stream.out_valid !== 1'b0 || stream.out_last !== 1'b0 ||
        stream.out_data !== '0 || mem_address !== base) begin
      errors++;
      $display("FAIL %s: got done=%b v=%b l=%b d=%h a=%h exp done=1 v=0 l=0 d=0 a=%h",
               name, done, stream.out_valid, stream.out_last, stream.out_data, mem_address, base);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_address = 14'h0100;
    row_size = '0; col_size = '0; stream.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_values", 14'h0100);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset_idle", 14'h0100);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 6; i++) mem[14'h0100 + i] = 16'h3C00 + 16'(i);
    run_drain("basic", 14'h0100, 3, 2, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    run_drain("backpressure", 14'h0100, 3, 2, 1, 0, 0, 0);
  endtask

  task automatic test_zero_size();
    logic [ADDR_W-1:0] base;
    base = 14'h0200;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      start_address = base;
      row_size = (v == 0) ? 10'd0 : 10'd3;
      col_size = (v == 0) ? 10'd5 : 10'd0;
      start = 1'b1;
      stream.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
        checks++;
        if (done !== 1'b1 || stream.out_valid !== 1'b0 || mem_address !== base) begin
          errors++;
          $display("FAIL zero_size v%0d cyc %0d: got done=%b v=%b a=%h exp done=1 v=0 a=%h",
                   v, c, done, stream.out_valid, mem_address, base);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_addr_wrap();
    mem[14'h3FFE] = 16'hA001; mem[14'h3FFF] = 16'hA002;
    mem[14'h0000] = 16'hA003; mem[14'h0001] = 16'hA004;
    run_drain("addr_wrap", 14'h3FFE, 4, 1, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_run();
    run_drain("abort", 14'h0100, 3, 2, 0, 2, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_run", 14'h0100);
    reset = 1'b0;
    run_drain("replay", 14'h0100, 3, 2, 0, 0, 0, 1);
  endtask

  task automatic test_row_last();
    run_drain("row_last", 14'h0500, 2, 3, 2, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_drain("random", ADDR_W'($urandom), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 5)), 2, 0, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_size();
    test_addr_wrap();
    test_reset_mid_run();
    test_row_last();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
